// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - request, response and memory-controller signal bundle for mem_stage_lsu
interface mem_stage_lsu_if #(
  parameter int LANES  = 16,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 13,
  parameter int TAG_W  = 5
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_we;
  logic                         req_vec;
  logic [ADDR_W-1:0]            req_addr;
  logic [LANES-1:0][WORD_W-1:0] req_wdata;
  logic [TAG_W-1:0]             req_tag;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [LANES-1:0][WORD_W-1:0] rsp_data;
  logic [TAG_W-1:0]             rsp_tag;
  logic                         rsp_vec;
  logic                         rsp_err;

  logic [ADDR_W-1:0]            mem_address;
  logic [LANES-1:0][WORD_W-1:0] mem_data;
  logic                         mem_wren;
  logic                         mem_vec_scalar;
  logic [LANES-1:0][WORD_W-1:0] mem_q;

  modport slave (
    input  req_valid, req_we, req_vec, req_addr, req_wdata, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_vec, rsp_err,
    input  rsp_ready,
    output mem_address, mem_data, mem_wren, mem_vec_scalar,
    input  mem_q
  );

  modport master (
    output req_valid, req_we, req_vec, req_addr, req_wdata, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_vec, rsp_err,
    output rsp_ready,
    input  mem_address, mem_data, mem_wren, mem_vec_scalar,
    output mem_q
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - load/store sequencer for the banked memory controller; MEM_BOUNDS_CHECK_EN enables vector bounds flagging
module mem_stage_lsu #(
  parameter int LANES  = 16,
  parameter int WORD_W = 32,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1,
  parameter int TAG_W  = 5
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int CNT_W = 3;

  state_t                       state;
  state_t                       state_nxt;
  logic                         accept;
  logic                         flag;
  logic [CNT_W-1:0]             cnt;
  logic [ADDR_W-1:0]            address_q;
  logic [LANES-1:0][WORD_W-1:0] data_q;
  logic [LANES-1:0][WORD_W-1:0] rdata_q;
  logic [LANES-1:0][WORD_W-1:0] store_map;
  logic [LANES-1:0][WORD_W-1:0] load_map;
  logic                         wren_q;
  logic                         vec_mode_q;
  logic                         rsp_valid_q;
  logic                         rsp_vec_q;
  logic [TAG_W-1:0]             tag_q;
  logic                         mem_q_unused;

  assign bus.req_ready      = rst && (state == IDLE);
  assign accept             = bus.req_valid && bus.req_ready;

  assign bus.mem_address    = address_q;
  assign bus.mem_data       = data_q;
  assign bus.mem_wren       = wren_q;
  assign bus.mem_vec_scalar = vec_mode_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rdata_q;
  assign bus.rsp_tag        = tag_q;
  assign bus.rsp_vec        = rsp_vec_q;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'((1 << ADDR_W) - LANES);

  logic err_q;

  assign flag = bus.req_vec && (bus.req_addr > MAX_BASE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept && !bus.req_we) begin
      err_q <= flag;
    end else if (state == RESP && bus.rsp_ready) begin
      err_q <= 1'b0;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign flag        = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_we) begin
            state_nxt = flag ? IDLE : WR;
          end else begin
            state_nxt = flag ? RESP : RD_WAIT;
          end
        end
      end
      WR:      state_nxt = IDLE;
      RD_WAIT: if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In scalar mode the controller's bank 0 reads its data from the top lane.
  always_comb begin
    store_map = '0;
    if (bus.req_vec) begin
      store_map = bus.req_wdata;
    end else begin
      store_map[0]       = bus.req_wdata[0];
      store_map[LANES-1] = bus.req_wdata[0];
    end
  end

  always_comb begin
    load_map     = '0;
    mem_q_unused = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (vec_mode_q || i == 0) begin
        load_map[i][ELEM_W-1:0] = bus.mem_q[i][ELEM_W-1:0];
      end
      mem_q_unused = mem_q_unused ^ (^bus.mem_q[i][WORD_W-1:ELEM_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      address_q   <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      wren_q      <= 1'b0;
      vec_mode_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_vec_q   <= 1'b0;
      tag_q       <= '0;
    end else begin
      wren_q      <= (state_nxt == WR);
      rsp_valid_q <= (state_nxt == RESP);
      if (accept) begin
        address_q  <= bus.req_addr;
        vec_mode_q <= bus.req_vec;
        data_q     <= store_map;
        cnt        <= CNT_W'(RD_LAT);
        if (!bus.req_we) begin
          tag_q     <= bus.req_tag;
          rsp_vec_q <= bus.req_vec;
          if (flag) begin
            rdata_q <= '0;
          end
        end
      end else if (state == RD_WAIT) begin
        // cnt reaches zero in the cycle where mem_q reflects the held address
        if (cnt == '0) begin
          rdata_q <= load_map;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu against a behavioural memory controller model
module tb_mem_stage_lsu;
  localparam int LANES   = 16;
  localparam int WORD_W  = 32;
  localparam int ELEM_W  = 16;
  localparam int ADDR_W  = 13;
  localparam int RD_LAT  = 1;
  localparam int TAG_W   = 5;
  localparam int EXP_LAT = RD_LAT + 2;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef logic [LANES-1:0][WORD_W-1:0] lanes_t;
  typedef struct {
    lanes_t           data;
    logic [TAG_W-1:0] tag;
    logic             vec;
    logic             err;
    int               lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic clear_mem;
  int   checks = 0;
  int   errors = 0;
  rsp_t sb_q[$];

  logic [ELEM_W-1:0] shadow    [DEPTH];
  logic [ELEM_W-1:0] model_mem [DEPTH];
  lanes_t            q_pipe    [RD_LAT];

  mem_stage_lsu_if #(.LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  mem_stage_lsu #(
    .LANES(LANES), .WORD_W(WORD_W), .ELEM_W(ELEM_W),
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_q = q_pipe[RD_LAT-1];

  // Controller model: shares the reset, junk in the upper bits of every lane.
  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      q_pipe[0][i] <= {16'hDEAD, model_mem[(int'(bus.mem_address) + i) % DEPTH]};
    end
    for (int k = 1; k < RD_LAT; k++) q_pipe[k] <= q_pipe[k-1];
    if (clear_mem) begin
      for (int j = 0; j < DEPTH; j++) model_mem[j] <= '0;
    end else if (rst && bus.mem_wren) begin
      if (bus.mem_vec_scalar) begin
        for (int i = 0; i < LANES; i++)
          model_mem[(int'(bus.mem_address) + i) % DEPTH] <= bus.mem_data[i][ELEM_W-1:0];
      end else begin
        model_mem[bus.mem_address] <= bus.mem_data[0][ELEM_W-1:0];
      end
    end
  end

  task automatic shadow_store(input logic [ADDR_W-1:0] a, input logic v, input lanes_t wd);
    for (int i = 0; i < LANES; i++) begin
      if (v) shadow[(int'(a) + i) % DEPTH] = wd[i][ELEM_W-1:0];
    end
    if (!v) shadow[a] = wd[0][ELEM_W-1:0];
  endtask

  function automatic lanes_t exp_load(input logic [ADDR_W-1:0] a, input logic v);
    lanes_t e;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      if (v || i == 0) e[i][ELEM_W-1:0] = shadow[(int'(a) + i) % DEPTH];
    end
    return e;
  endfunction

  task automatic send_req(input logic we, input logic vec, input logic [ADDR_W-1:0] addr,
                          input lanes_t wdata, input logic [TAG_W-1:0] tag, output int waited);
    bit ok;
    ok            = 1'b0;
    waited        = 0;
    bus.req_we    = we;
    bus.req_vec   = vec;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge clk);
      waited++;
      if (bus.req_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got req_ready=0 want 1 within 32 cycles");
    end
  endtask

  task automatic get_rsp(output rsp_t r);
    bit ok;
    ok     = 1'b0;
    r.lat  = 0;
    r.data = '0;
    r.tag  = '0;
    r.vec  = 1'b0;
    r.err  = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      r.lat++;
      if (bus.rsp_valid === 1'b1) begin
        ok     = 1'b1;
        r.data = bus.rsp_data;
        r.tag  = bus.rsp_tag;
        r.vec  = bus.rsp_vec;
        r.err  = bus.rsp_err;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_timeout got rsp_valid=0 want 1 within 64 cycles");
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    clear_mem     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_vec   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) shadow[j] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_req_ready got %b want 0", bus.req_ready);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.mem_wren, bus.mem_vec_scalar} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b want 0000",
                         {bus.rsp_valid, bus.rsp_err, bus.mem_wren, bus.mem_vec_scalar});
    end
    checks++;
    if (bus.rsp_data !== '0 || bus.mem_data !== '0) begin
      errors++; $display("FAIL rst_data got rsp=%h mem=%h want 0", bus.rsp_data, bus.mem_data);
    end
    checks++;
    if (bus.mem_address !== '0 || bus.rsp_tag !== '0 || bus.rsp_vec !== 1'b0) begin
      errors++; $display("FAIL rst_addr_tag got addr=%h tag=%h vec=%b want 0",
                         bus.mem_address, bus.rsp_tag, bus.rsp_vec);
    end
    clear_mem = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready got %b want 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vector_store();
    lanes_t wd;
    int     w;
    for (int i = 0; i < LANES; i++) wd[i] = 32'h1000 + i;
    send_req(1'b1, 1'b1, 13'h010, wd, '0, w);
    shadow_store(13'h010, 1'b1, wd);
    @(negedge clk);
    checks++;
    if (bus.mem_wren !== 1'b1 || bus.mem_vec_scalar !== 1'b1) begin
      errors++; $display("FAIL vst_ctrl got wren=%b vec=%b want 1 1", bus.mem_wren, bus.mem_vec_scalar);
    end
    checks++;
    if (bus.mem_data[5] !== 32'h0000_1005 || bus.mem_address !== 13'h010) begin
      errors++; $display("FAIL vst_data got d5=%h addr=%h want 00001005 010", bus.mem_data[5], bus.mem_address);
    end
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL vst_ready_t1 got %b want 0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL vst_t2 got wren=%b ready=%b want 0 1", bus.mem_wren, bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vector_load();
    rsp_t got, exp;
    int   w;
    sb_q.push_back('{exp_load(13'h010, 1'b1), 5'h13, 1'b1, 1'b0, EXP_LAT});
    send_req(1'b0, 1'b1, 13'h010, '0, 5'h13, w);
    get_rsp(got);
    exp = sb_q.pop_front();
    checks++;
    if (got.data !== exp.data) begin
      errors++; $display("FAIL vld_data got %h want %h", got.data, exp.data);
    end
    checks++;
    if (got.data[9] !== 32'h0000_1009) begin
      errors++; $display("FAIL vld_lane9 got %h want 00001009", got.data[9]);
    end
    checks++;
    if (got.tag !== exp.tag || got.vec !== exp.vec || got.err !== exp.err) begin
      errors++; $display("FAIL vld_meta got tag=%h vec=%b err=%b want %h %b %b",
                         got.tag, got.vec, got.err, exp.tag, exp.vec, exp.err);
    end
    checks++;
    if (got.lat !== exp.lat) begin
      errors++; $display("FAIL vld_latency got T+%0d want T+%0d", got.lat, exp.lat);
    end
  endtask

  task automatic test_scalar();
    lanes_t wd;
    rsp_t   got, exp;
    int     w;
    for (int i = 0; i < LANES; i++) wd[i] = 32'h5555_0000 + i;
    wd[0] = 32'hABCD_1234;
    send_req(1'b1, 1'b0, 13'h020, wd, '0, w);
    shadow_store(13'h020, 1'b0, wd);
    @(negedge clk);
    checks++;
    if (bus.mem_data[0] !== 32'hABCD_1234 || bus.mem_data[15] !== 32'hABCD_1234) begin
      errors++; $display("FAIL sst_lanes got d0=%h d15=%h want abcd1234", bus.mem_data[0], bus.mem_data[15]);
    end
    checks++;
    if (bus.mem_data[7] !== '0 || bus.mem_vec_scalar !== 1'b0 || bus.mem_wren !== 1'b1) begin
      errors++; $display("FAIL sst_mode got d7=%h vec=%b wren=%b want 0 0 1",
                         bus.mem_data[7], bus.mem_vec_scalar, bus.mem_wren);
    end
    @(posedge clk);
    #1;
    sb_q.push_back('{exp_load(13'h020, 1'b0), 5'h02, 1'b0, 1'b0, EXP_LAT});
    send_req(1'b0, 1'b0, 13'h020, '0, 5'h02, w);
    get_rsp(got);
    exp = sb_q.pop_front();
    checks++;
    if (got.data !== exp.data) begin
      errors++; $display("FAIL sld_data got %h want %h", got.data, exp.data);
    end
    checks++;
    if (got.data[0] !== 32'h0000_1234 || got.vec !== 1'b0 || got.tag !== exp.tag) begin
      errors++; $display("FAIL sld_lane0 got %h vec=%b tag=%h want 00001234 0 %h",
                         got.data[0], got.vec, got.tag, exp.tag);
    end
  endtask

  task automatic test_backpressure();
    rsp_t   exp;
    lanes_t held;
    bit     ok;
    int     w;
    bus.rsp_ready = 1'b0;
    sb_q.push_back('{exp_load(13'h010, 1'b1), 5'h07, 1'b1, 1'b0, EXP_LAT});
    send_req(1'b0, 1'b1, 13'h010, '0, 5'h07, w);
    ok = 1'b0;
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) ok = 1'b1;
    end
    held = bus.rsp_data;
    exp  = sb_q.pop_front();
    checks++;
    if (!ok || held !== exp.data) begin
      errors++; $display("FAIL bp_data got valid=%b data=%h want 1 %h", ok, held, exp.data);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.rsp_tag !== 5'h07 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got valid=%b tag=%h ready=%b want 1 07 0",
                           c, bus.rsp_valid, bus.rsp_tag, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    lanes_t wd;
    rsp_t   got, exp;
    bit     saw;
    int     w;
    send_req(1'b0, 1'b1, 13'h010, '0, 5'h04, w);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.mem_wren !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL rd_abort got valid=%b wren=%b ready=%b want 0 0 0",
                         bus.rsp_valid, bus.mem_wren, bus.req_ready);
    end
    rst = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rd_abort_idle got late_rsp=%b ready=%b want 0 1", saw, bus.req_ready);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < LANES; i++) wd[i] = 32'h2000 + i;
    send_req(1'b1, 1'b1, 13'h040, wd, '0, w);
    shadow_store(13'h040, 1'b1, wd);
    @(posedge clk);
    #1;
    for (int i = 0; i < LANES; i++) wd[i] = 32'h3000 + i;
    send_req(1'b1, 1'b1, 13'h040, wd, '0, w);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL wr_abort got wren=%b ready=%b want 0 0", bus.mem_wren, bus.req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_abort_idle got ready=%b want 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    sb_q.push_back('{exp_load(13'h040, 1'b1), 5'h0A, 1'b1, 1'b0, EXP_LAT});
    send_req(1'b0, 1'b1, 13'h040, '0, 5'h0A, w);
    get_rsp(got);
    exp = sb_q.pop_front();
    checks++;
    if (got.data !== exp.data || got.data[3] !== 32'h0000_2003) begin
      errors++; $display("FAIL wr_abort_readback got %h want %h", got.data, exp.data);
    end
  endtask

  task automatic test_bounds();
    lanes_t wd;
    rsp_t   got, exp;
    bit     saw;
    int     w;
    for (int i = 0; i < LANES; i++) wd[i] = 32'h4000 + i;
    send_req(1'b1, 1'b1, 13'h1FF5, wd, '0, w);
    saw = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.mem_wren === 1'b1) saw = 1'b1;
    end
`ifdef MEM_BOUNDS_CHECK_EN
    checks++;
    if (saw !== 1'b0) begin
      errors++; $display("FAIL bnd_store got wren_seen=%b want 0", saw);
    end
    sb_q.push_back('{lanes_t'('0), 5'h1F, 1'b1, 1'b1, 1});
`else
    checks++;
    if (saw !== 1'b1) begin
      errors++; $display("FAIL wrap_store got wren_seen=%b want 1", saw);
    end
    shadow_store(13'h1FF5, 1'b1, wd);
    sb_q.push_back('{exp_load(13'h1FF5, 1'b1), 5'h1F, 1'b1, 1'b0, EXP_LAT});
`endif
    @(posedge clk);
    #1;
    send_req(1'b0, 1'b1, 13'h1FF5, '0, 5'h1F, w);
    get_rsp(got);
    exp = sb_q.pop_front();
    checks++;
    if (got.data !== exp.data || got.tag !== exp.tag) begin
      errors++; $display("FAIL bnd_vload_data got %h tag=%h want %h %h", got.data, got.tag, exp.data, exp.tag);
    end
    checks++;
    if (got.err !== exp.err || got.lat !== exp.lat) begin
      errors++; $display("FAIL bnd_vload_err got err=%b T+%0d want %b T+%0d", got.err, got.lat, exp.err, exp.lat);
    end
    checks++;
    if (bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL bnd_err_clear got %b want 0", bus.rsp_err);
    end
    sb_q.push_back('{exp_load(13'h1FF5, 1'b0), 5'h1E, 1'b0, 1'b0, EXP_LAT});
    send_req(1'b0, 1'b0, 13'h1FF5, '0, 5'h1E, w);
    get_rsp(got);
    exp = sb_q.pop_front();
    checks++;
    if (got.data !== exp.data || got.err !== exp.err || got.lat !== exp.lat) begin
      errors++; $display("FAIL bnd_scalar got %h err=%b T+%0d want %h %b T+%0d",
                         got.data, got.err, got.lat, exp.data, exp.err, exp.lat);
    end
  endtask

  task automatic test_back_to_back();
    lanes_t           wd;
    rsp_t             got, exp;
    logic [ADDR_W-1:0] a;
    logic             v, we;
    logic [TAG_W-1:0] t;
    int               w;
    for (int i = 0; i < LANES; i++) wd[i] = 32'h6000 + i;
    send_req(1'b1, 1'b1, 13'h080, wd, '0, w);
    shadow_store(13'h080, 1'b1, wd);
    send_req(1'b1, 1'b0, 13'h090, wd, '0, w);
    shadow_store(13'h090, 1'b0, wd);
    checks++;
    if (w !== 2) begin
      errors++; $display("FAIL store_throughput got accept after %0d cycles want 2", w);
    end
    for (int n = 0; n < 16; n++) begin
      a  = ADDR_W'($urandom_range(32'h080, 32'h0BF));
      v  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      t  = TAG_W'($urandom_range(0, 31));
      if (we) begin
        for (int i = 0; i < LANES; i++) wd[i] = $urandom;
        send_req(1'b1, v, a, wd, '0, w);
        shadow_store(a, v, wd);
      end else begin
        sb_q.push_back('{exp_load(a, v), t, v, 1'b0, EXP_LAT});
        send_req(1'b0, v, a, '0, t, w);
        get_rsp(got);
        exp = sb_q.pop_front();
        checks++;
        if (got.data !== exp.data || got.tag !== exp.tag || got.vec !== exp.vec || got.lat !== exp.lat) begin
          errors++; $display("FAIL rand_load %0d addr=%h got %h tag=%h T+%0d want %h %h T+%0d",
                             n, a, got.data, got.tag, got.lat, exp.data, exp.tag, exp.lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector_store();
    test_vector_load();
    test_scalar();
    test_backpressure();
    test_reset_abort();
    test_bounds();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000 time units");
    $fatal(1);
  end
endmodule
